// File: rtl/pci_parity_gen_check_if.sv
// pci_parity_gen_check_if: pad-side AD/CBE/PAR/PERR#/SERR# signals around the parity block.
interface pci_parity_gen_check_if;
    logic [31:0] pci_ad_out_next;
    logic [3:0]  pci_cbe_l_out_next;
    logic        pci_ad_out_en_next;
    logic        pci_ad_out_oe_comb;
    logic        pci_par_out_next;
    logic        pci_par_out_en_next;
    logic        pci_par_out_oe_comb;
    logic [31:0] pci_ad_in_prev;
    logic [3:0]  pci_cbe_l_in_prev;
    logic        pci_par_in_prev;
    logic        pci_perr_out_next;
    logic        pci_perr_out_en_next;
    logic        pci_perr_out_oe_comb;
    logic        pci_serr_out_next;
    logic        pci_serr_out_oe_comb;

    modport master (
        input  pci_ad_out_next, pci_cbe_l_out_next, pci_ad_out_en_next, pci_ad_out_oe_comb,
        input  pci_ad_in_prev, pci_cbe_l_in_prev, pci_par_in_prev,
        output pci_par_out_next, pci_par_out_en_next, pci_par_out_oe_comb,
        output pci_perr_out_next, pci_perr_out_en_next, pci_perr_out_oe_comb,
        output pci_serr_out_next, pci_serr_out_oe_comb
    );

    modport slave (
        output pci_ad_out_next, pci_cbe_l_out_next, pci_ad_out_en_next, pci_ad_out_oe_comb,
        output pci_ad_in_prev, pci_cbe_l_in_prev, pci_par_in_prev,
        input  pci_par_out_next, pci_par_out_en_next, pci_par_out_oe_comb,
        input  pci_perr_out_next, pci_perr_out_en_next, pci_perr_out_oe_comb,
        input  pci_serr_out_next, pci_serr_out_oe_comb
    );
endinterface

// File: rtl/pci_parity_gen_check.sv
// pci_parity_gen_check: PAR generation one clock behind AD, PAR checking with PERR#/SERR# drive and sticky status.
module pci_parity_gen_check #(
    parameter int ERR_CNT_WIDTH = 8
) (
    input  logic                     pci_clk,
    input  logic                     pci_reset_comb,
    pci_parity_gen_check_if.master   pad,
    input  logic                     check_data_phase,
    input  logic                     check_addr_phase,
    input  logic                     parity_err_response,
    input  logic                     serr_enable,
    input  logic                     status_clear,
    output logic                     detected_parity_error,
    output logic                     signaled_serr,
    output logic [ERR_CNT_WIDTH-1:0] parity_err_count
);
    typedef enum logic [1:0] {PERR_IDLE, PERR_ASSERT, PERR_RELEASE} perr_state_t;

    perr_state_t state, state_next;
    logic par_reg, par_oe, calc_reg, dq_reg, aq_reg, perr_oe, serr_oe;
    logic data_err, addr_err, any_err, serr_fire;

    always_ff @(posedge pci_clk) begin
        if (pci_reset_comb) begin
            par_reg <= 1'b0;
            par_oe  <= 1'b0;
        end else begin
            if (pad.pci_ad_out_en_next) par_reg <= ^{pad.pci_ad_out_next, pad.pci_cbe_l_out_next};
            par_oe <= pad.pci_ad_out_oe_comb;
        end
    end

    // PAR for a phase arrives one edge after its AD/CBE#, so the computed parity waits here
    always_ff @(posedge pci_clk) begin
        if (pci_reset_comb) begin
            calc_reg <= 1'b0;
            dq_reg   <= 1'b0;
            aq_reg   <= 1'b0;
        end else begin
            calc_reg <= ^{pad.pci_ad_in_prev, pad.pci_cbe_l_in_prev};
            dq_reg   <= check_data_phase;
            aq_reg   <= check_addr_phase;
        end
    end

    always_comb begin
        data_err   = dq_reg & (calc_reg ^ pad.pci_par_in_prev);
        addr_err   = aq_reg & (calc_reg ^ pad.pci_par_in_prev);
        any_err    = data_err | addr_err;
        serr_fire  = addr_err & parity_err_response & serr_enable;
        state_next = (data_err & parity_err_response) ? PERR_ASSERT :
                     (state == PERR_ASSERT)           ? PERR_RELEASE : PERR_IDLE;
    end

    always_ff @(posedge pci_clk) begin
        if (pci_reset_comb) begin
            state   <= PERR_IDLE;
            perr_oe <= 1'b0;
            serr_oe <= 1'b0;
        end else begin
            state   <= state_next;
            perr_oe <= state_next != PERR_IDLE;
            serr_oe <= serr_fire;
        end
    end

    // a new error on the same edge as status_clear wins over the clear
    always_ff @(posedge pci_clk) begin
        if (pci_reset_comb) begin
            detected_parity_error <= 1'b0;
            signaled_serr         <= 1'b0;
            parity_err_count      <= '0;
        end else begin
            if (any_err) detected_parity_error <= 1'b1;
            else if (status_clear) detected_parity_error <= 1'b0;
            if (serr_fire) signaled_serr <= 1'b1;
            else if (status_clear) signaled_serr <= 1'b0;
            if (any_err)
                parity_err_count <= status_clear     ? ERR_CNT_WIDTH'(1) :
                                    &parity_err_count ? parity_err_count :
                                    parity_err_count + ERR_CNT_WIDTH'(1);
            else if (status_clear) parity_err_count <= '0;
        end
    end

    assign pad.pci_par_out_next     = par_reg;
    assign pad.pci_par_out_en_next  = 1'b1;
    assign pad.pci_par_out_oe_comb  = par_oe;
    assign pad.pci_perr_out_next    = state_next != PERR_ASSERT;
    assign pad.pci_perr_out_en_next = 1'b1;
    assign pad.pci_perr_out_oe_comb = perr_oe;
    assign pad.pci_serr_out_next    = 1'b0;
    assign pad.pci_serr_out_oe_comb = serr_oe;
endmodule
